// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding and default constants for the pc/branch stage
//   ST_RUN/ST_REDIRECT/ST_HALTED : FSM state encoding
//   PC_W_DEF, RESET_PC_DEF       : default pc width and reset address
package pc_pkg;
   localparam int PC_W_DEF = 16;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;
   localparam logic [1:0] ST_RUN = 2'd0;
   localparam logic [1:0] ST_REDIRECT = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;
   typedef enum logic [1:0] {
      RUN = ST_RUN,
      REDIRECT = ST_REDIRECT,
      HALTED = ST_HALTED
   } state_t;
endpackage

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses
//   clk, reset : clock, async active-high reset (clears count only)
//   push, pop  : write din on top / discard top
//   din, dout  : pushed value / current top of stack
//   full, empty: count == DEPTH / count == 0
module return_stack #(
   parameter int DEPTH = 4,
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] count;
   logic [AW-1:0] top;
   assign top = AW'(count - 1'b1);
   assign dout = mem[top];
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (push && !full) count <= count + 1'b1;
      else if (pop && !empty) count <= count - 1'b1;
   always_ff @(posedge clk)
      if (push && !full) mem[count[AW-1:0]] <= din;
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter with branch/jump/call/return resolution
//   clk, reset         : clock, async active-high reset
//   step               : advance one instruction
//   branch, jump       : conditional branch and its compare result
//   uncond, call, ret  : unconditional jump, call (push pc+1), return (pop)
//   halt               : halt instruction
//   target             : redirect destination
//   pc                 : current instruction address
//   flush              : one-cycle redirect bubble
//   halted             : in HALTED state
//   stack_overflow/underflow : sticky return-stack error flags
module pc_branch_unit import pc_pkg::*; #(
   parameter int PC_W = PC_W_DEF,
   parameter int STACK_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            step,
   input  logic            branch,
   input  logic            jump,
   input  logic            uncond,
   input  logic            call,
   input  logic            ret,
   input  logic            halt,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc,
   output logic            flush,
   output logic            halted,
   output logic            stack_overflow,
   output logic            stack_underflow
);
   state_t state, state_nxt;
   logic [PC_W-1:0] pc_nxt, pc_inc, top;
   logic push, pop, ovf_set, unf_set, full, empty;
   assign pc_inc = pc + 1'b1;
   return_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
      .clk(clk), .reset(reset), .push(push), .pop(pop),
      .din(pc_inc), .dout(top), .full(full), .empty(empty)
   );
   // one action per step, in fixed priority: halt, ret, call, uncond, taken branch, increment
   always_comb begin
      state_nxt = state;
      pc_nxt = pc;
      push = 1'b0;
      pop = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      case (state)
         RUN:
            if (step) begin
               if (halt) state_nxt = HALTED;
               else if (ret) begin
                  pop = !empty;
                  unf_set = empty;
                  pc_nxt = empty ? pc : top;
                  state_nxt = empty ? HALTED : REDIRECT;
               end else if (call) begin
                  push = !full;
                  ovf_set = full;
                  pc_nxt = full ? pc : target;
                  state_nxt = full ? HALTED : REDIRECT;
               end else if (uncond || (branch && jump)) begin
                  pc_nxt = target;
                  state_nxt = REDIRECT;
               end else pc_nxt = pc_inc;
            end
         REDIRECT: state_nxt = RUN;
         HALTED: state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= RUN;
         pc <= RESET_PC;
         flush <= 1'b0;
         halted <= 1'b0;
         stack_overflow <= 1'b0;
         stack_underflow <= 1'b0;
      end else begin
         state <= state_nxt;
         pc <= pc_nxt;
         flush <= state_nxt == REDIRECT;
         halted <= state_nxt == HALTED;
         stack_overflow <= stack_overflow | ovf_set;
         stack_underflow <= stack_underflow | unf_set;
      end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed scoreboard bench for pc_branch_unit
module tb_pc_branch_unit;
   typedef struct packed {
      logic [15:0] pc;
      logic flush;
      logic halted;
      logic ovf;
      logic unf;
   } obs_t;
   localparam logic [6:0] S = 7'b1000000, BR = 7'b0100000, J = 7'b0010000,
      U = 7'b0001000, C = 7'b0000100, R = 7'b0000010, H = 7'b0000001;
   logic clk = 1'b0, reset = 1'b1;
   logic step = 0, branch = 0, jump = 0, uncond = 0, call = 0, ret = 0, halt = 0;
   logic [15:0] target = '0;
   logic [15:0] pc;
   logic flush, halted, stack_overflow, stack_underflow;
   obs_t obs, exp_v;
   obs_t exp_q[$];
   int checks = 0, errors = 0;
   assign obs = {pc, flush, halted, stack_overflow, stack_underflow};
   pc_branch_unit dut (
      .clk(clk), .reset(reset), .step(step), .branch(branch), .jump(jump),
      .uncond(uncond), .call(call), .ret(ret), .halt(halt), .target(target),
      .pc(pc), .flush(flush), .halted(halted),
      .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   function automatic obs_t e(logic [15:0] p, logic f, logic h, logic o, logic u);
      return '{pc: p, flush: f, halted: h, ovf: o, unf: u};
   endfunction
   task automatic sample(string tag);
      exp_v = exp_q.pop_front();
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed pc=%h fl=%b h=%b ovf=%b unf=%b, expected pc=%h fl=%b h=%b ovf=%b unf=%b",
            tag, obs.pc, obs.flush, obs.halted, obs.ovf, obs.unf,
            exp_v.pc, exp_v.flush, exp_v.halted, exp_v.ovf, exp_v.unf);
      end
   endtask
   task automatic go(string tag, logic [6:0] ctl, logic [15:0] tg, obs_t ex);
      {step, branch, jump, uncond, call, ret, halt} = ctl;
      target = tg;
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      sample(tag);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      exp_q.push_back(e(16'h0000, 0, 0, 0, 0));
      #1;
      sample("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask
   initial begin
      @(posedge clk);
      #1;
      do_reset();
      for (int i = 1; i <= 5; i++) go("seq", S, 16'h0, e(16'(i), 0, 0, 0, 0));
      go("hold", 7'd0, 16'h0, e(16'h0005, 0, 0, 0, 0));
      go("jmp_fffe", S | U, 16'hFFFE, e(16'hFFFE, 1, 0, 0, 0));
      go("bubble", 7'd0, 16'h0, e(16'hFFFE, 0, 0, 0, 0));
      go("inc_ffff", S, 16'h0, e(16'hFFFF, 0, 0, 0, 0));
      go("wrap", S, 16'h0, e(16'h0000, 0, 0, 0, 0));
      go("jmp_10", S | U, 16'h0010, e(16'h0010, 1, 0, 0, 0));
      go("bubble", 7'd0, 16'h0, e(16'h0010, 0, 0, 0, 0));
      go("br_nt", S | BR, 16'h0040, e(16'h0011, 0, 0, 0, 0));
      go("br_t", S | BR | J, 16'h0040, e(16'h0040, 1, 0, 0, 0));
      go("redir_ign", S | BR | J | C, 16'h0099, e(16'h0040, 0, 0, 0, 0));
      go("after", S, 16'h0, e(16'h0041, 0, 0, 0, 0));
      go("jump_only", S | J, 16'h0077, e(16'h0042, 0, 0, 0, 0));
      go("br_self", S | BR | J, 16'h0042, e(16'h0042, 1, 0, 0, 0));
      go("bubble", 7'd0, 16'h0, e(16'h0042, 0, 0, 0, 0));
      go("jmp_100", S | U, 16'h0100, e(16'h0100, 1, 0, 0, 0));
      go("bubble", 7'd0, 16'h0, e(16'h0100, 0, 0, 0, 0));
      for (int i = 2; i <= 5; i++) begin
         go("call", S | C, 16'(i * 256), e(16'(i * 256), 1, 0, 0, 0));
         go("bubble", 7'd0, 16'h0, e(16'(i * 256), 0, 0, 0, 0));
      end
      for (int i = 4; i >= 1; i--) begin
         go("ret", S | R | C | U, 16'h0FFF, e(16'(i * 256 + 1), 1, 0, 0, 0));
         go("bubble", 7'd0, 16'h0, e(16'(i * 256 + 1), 0, 0, 0, 0));
      end
      for (int i = 2; i <= 5; i++) begin
         go("call2", S | C, 16'(i * 256), e(16'(i * 256), 1, 0, 0, 0));
         go("bubble", 7'd0, 16'h0, e(16'(i * 256), 0, 0, 0, 0));
      end
      go("ovf", S | C, 16'h0600, e(16'h0500, 0, 1, 1, 0));
      go("halt_ret", S | R, 16'h0, e(16'h0500, 0, 1, 1, 0));
      go("halt_jmp", S | U, 16'h0123, e(16'h0500, 0, 1, 1, 0));
      do_reset();
      go("unf", S | R, 16'h0, e(16'h0000, 0, 1, 0, 1));
      go("halt_stay", S, 16'h0, e(16'h0000, 0, 1, 0, 1));
      do_reset();
      go("jmp_ffff", S | U, 16'hFFFF, e(16'hFFFF, 1, 0, 0, 0));
      go("bubble", 7'd0, 16'h0, e(16'hFFFF, 0, 0, 0, 0));
      go("call_wrap", S | C, 16'h0123, e(16'h0123, 1, 0, 0, 0));
      go("bubble", 7'd0, 16'h0, e(16'h0123, 0, 0, 0, 0));
      go("ret_wrap", S | R, 16'h0, e(16'h0000, 1, 0, 0, 0));
      go("bubble", 7'd0, 16'h0, e(16'h0000, 0, 0, 0, 0));
      go("halt_prio", S | H | C | U, 16'h0055, e(16'h0000, 0, 1, 0, 0));
      do_reset();
      go("jmp_777", S | U, 16'h0777, e(16'h0777, 1, 0, 0, 0));
      #2;
      do_reset();
      go("post_rst", S, 16'h0, e(16'h0001, 0, 0, 0, 0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
